// File: rtl/sbit_tap_delay.sv
// Multi-channel programmable tap delay line with registered output, fill tracking, flush and runtime tap writes.
// Optional macro SBIT_TAP_GLITCHLESS_EN: taps slew one step per ce edge toward the written target.
module sbit_tap_delay #(
    parameter int NCH         = 8,
    parameter int WIDTH       = 1,
    parameter int SELWIDTH    = 5,
    parameter int CHW         = 3,
    parameter int DEFAULT_TAP = 0
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   ce_i,
    input  logic                   flush_i,
    input  logic [NCH*WIDTH-1:0]   din_i,
    input  logic                   tap_wr_i,
    input  logic [CHW-1:0]         tap_ch_i,
    input  logic [SELWIDTH-1:0]    tap_i,
    output logic [NCH*WIDTH-1:0]   dout_o,
    output logic [NCH-1:0]         valid_o,
    output logic [NCH-1:0]         busy_o,
    output logic                   err_o
);

    localparam int                  DEPTH    = 2**SELWIDTH;
    localparam int                  FW       = SELWIDTH + 1;
    localparam logic [FW-1:0]       FILL_MAX = DEPTH[FW-1:0];
    localparam logic [SELWIDTH-1:0] TAP_RST  = DEFAULT_TAP[SELWIDTH-1:0];
    localparam logic [CHW:0]        NCH_EXT  = NCH[CHW:0];

    logic [DEPTH*WIDTH-1:0] r_data    [NCH];
    logic [FW-1:0]          r_fill    [NCH];
    logic [SELWIDTH-1:0]    r_tap_cur [NCH];
    logic [SELWIDTH-1:0]    r_tap_tgt [NCH];
    logic [NCH*WIDTH-1:0]   r_dout;
    logic [NCH-1:0]         r_valid;
    logic [NCH-1:0]         r_busy;
    logic                   r_err;

    logic [SELWIDTH-1:0]    w_cur_nxt [NCH];
    logic [SELWIDTH-1:0]    w_tgt_nxt [NCH];
    logic                   w_ch_ok;

    assign w_ch_ok = ({1'b0, tap_ch_i} < NCH_EXT);

    // Next tap state: accepted writes and, with slewing, one step per unflushed ce edge.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_cur_nxt[c] = r_tap_cur[c];
            w_tgt_nxt[c] = r_tap_tgt[c];
`ifdef SBIT_TAP_GLITCHLESS_EN
            // The step uses the pre-write target so a new write takes effect from the next ce edge.
            if (ce_i && !flush_i) begin
                if (r_tap_cur[c] < r_tap_tgt[c]) begin
                    w_cur_nxt[c] = r_tap_cur[c] + SELWIDTH'(1);
                end else if (r_tap_cur[c] > r_tap_tgt[c]) begin
                    w_cur_nxt[c] = r_tap_cur[c] - SELWIDTH'(1);
                end else begin
                    w_cur_nxt[c] = r_tap_cur[c];
                end
            end else begin
                w_cur_nxt[c] = r_tap_cur[c];
            end
            if (tap_wr_i && w_ch_ok && (tap_ch_i == CHW'(c))) begin
                w_tgt_nxt[c] = tap_i;
            end else begin
                w_tgt_nxt[c] = r_tap_tgt[c];
            end
`else
            if (tap_wr_i && w_ch_ok && (tap_ch_i == CHW'(c))) begin
                w_tgt_nxt[c] = tap_i;
                w_cur_nxt[c] = tap_i;
            end else begin
                w_tgt_nxt[c] = r_tap_tgt[c];
                w_cur_nxt[c] = r_tap_cur[c];
            end
`endif
        end
    end

    // Shift data, tap output, fill/valid tracking, tap registers and error pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < NCH; c++) begin
                r_data[c]    <= '0;
                r_fill[c]    <= '0;
                r_tap_cur[c] <= TAP_RST;
                r_tap_tgt[c] <= TAP_RST;
            end
            r_dout  <= '0;
            r_valid <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= tap_wr_i & ~w_ch_ok;
            for (int c = 0; c < NCH; c++) begin
                r_tap_cur[c] <= w_cur_nxt[c];
                r_tap_tgt[c] <= w_tgt_nxt[c];
`ifdef SBIT_TAP_GLITCHLESS_EN
                r_busy[c]    <= (w_cur_nxt[c] != w_tgt_nxt[c]);
`else
                r_busy[c]    <= 1'b0;
`endif
            end
            if (flush_i) begin
                for (int c = 0; c < NCH; c++) begin
                    r_data[c] <= '0;
                    r_fill[c] <= '0;
                end
                r_dout  <= '0;
                r_valid <= '0;
            end else if (ce_i) begin
                for (int c = 0; c < NCH; c++) begin
                    r_data[c] <= {r_data[c][(DEPTH-1)*WIDTH-1:0], din_i[c*WIDTH +: WIDTH]};
                    r_dout[c*WIDTH +: WIDTH] <= r_data[c][int'(r_tap_cur[c])*WIDTH +: WIDTH];
                    r_fill[c]  <= (r_fill[c] == FILL_MAX) ? r_fill[c] : r_fill[c] + FW'(1);
                    r_valid[c] <= (r_fill[c] > {1'b0, r_tap_cur[c]});
                end
            end else begin
                r_dout  <= r_dout;
                r_valid <= r_valid;
            end
        end
    end

    assign dout_o  = r_dout;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

endmodule

// File: tb/tb_sbit_tap_delay.sv
// Self-checking bench for sbit_tap_delay: randomized stimulus against a sample-history reference model.
module tb_sbit_tap_delay;

    localparam int NCH   = 6;
    localparam int WIDTH = 2;
    localparam int SW    = 5;
    localparam int CHW   = 3;
    localparam int DT    = 0;
    localparam int DEPTH = 32;
    localparam int HL    = 4096;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 ce, flush, tap_wr;
    logic [CHW-1:0]       tap_ch;
    logic [SW-1:0]        tap;
    logic [NCH*WIDTH-1:0] din, dout;
    logic [NCH-1:0]       valid, busy;
    logic                 err;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel history of every sample accepted since the last reset/flush.
    int                   m_n    [NCH];
    logic [WIDTH-1:0]     m_hist [NCH][HL];
    int                   m_cur  [NCH];
    int                   m_tgt  [NCH];
    logic [NCH*WIDTH-1:0] m_dout;
    logic [NCH-1:0]       m_valid, m_busy;
    logic                 m_err;

    always #5 clk = ~clk;

    sbit_tap_delay #(.NCH(NCH), .WIDTH(WIDTH), .SELWIDTH(SW), .CHW(CHW), .DEFAULT_TAP(DT)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .ce_i(ce), .flush_i(flush), .din_i(din),
        .tap_wr_i(tap_wr), .tap_ch_i(tap_ch), .tap_i(tap),
        .dout_o(dout), .valid_o(valid), .busy_o(busy), .err_o(err)
    );

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_n[c] = 0; m_cur[c] = DT; m_tgt[c] = DT;
        end
        m_dout = '0; m_valid = '0; m_busy = '0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        m_err = tap_wr && (int'(tap_ch) >= NCH);
        if (flush) begin
            for (int c = 0; c < NCH; c++) m_n[c] = 0;
            m_dout = '0; m_valid = '0;
        end else if (ce) begin
            for (int c = 0; c < NCH; c++) begin
                m_dout[c*WIDTH +: WIDTH] = (m_n[c] > m_cur[c]) ? m_hist[c][(m_n[c] - 1 - m_cur[c]) % HL] : '0;
                m_valid[c] = (((m_n[c] < DEPTH) ? m_n[c] : DEPTH) > m_cur[c]);
                m_hist[c][m_n[c] % HL] = din[c*WIDTH +: WIDTH];
                m_n[c]++;
            end
        end
`ifdef SBIT_TAP_GLITCHLESS_EN
        if (ce && !flush) begin
            for (int c = 0; c < NCH; c++) begin
                if (m_cur[c] < m_tgt[c]) m_cur[c]++;
                else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
            end
        end
        if (tap_wr && int'(tap_ch) < NCH) m_tgt[int'(tap_ch)] = int'(tap);
`else
        if (tap_wr && int'(tap_ch) < NCH) begin
            m_tgt[int'(tap_ch)] = int'(tap);
            m_cur[int'(tap_ch)] = int'(tap);
        end
`endif
        for (int c = 0; c < NCH; c++) m_busy[c] = (m_cur[c] != m_tgt[c]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; ce = 1'b0; flush = 1'b0; tap_wr = 1'b0;
        tap_ch = '0; tap = '0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic write_tap(input int ch, input int t);
        tap_wr = 1'b1; tap_ch = CHW'(ch); tap = SW'(t);
        cyc();
        tap_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        write_tap(4, 7);
        ce = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
        end
        tap_wr = 1'b1; tap_ch = 3'd7; tap = 5'd1;
        cyc();
        tap_wr = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL reset_pre_err got=%b want=1", err); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || valid !== '0 || busy !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async dout=%h valid=%b busy=%b err=%b want all zero", dout, valid, busy, err);
        end
        do_reset();
        ce = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid) begin
                errors++;
                $display("FAIL reset_model edge=%0d dout=%h valid=%b want dout=%h valid=%b", e, dout, valid, m_dout, m_valid);
            end
            checks++;
            if (valid !== ((e >= 2) ? {NCH{1'b1}} : {NCH{1'b0}})) begin
                errors++;
                $display("FAIL reset_valid edge=%0d got=%b want=%b", e, valid, (e >= 2) ? {NCH{1'b1}} : {NCH{1'b0}});
            end
        end
    endtask

    task automatic test_latency();
        int first_v, first_o;
        do_reset();
        write_tap(0, 5);
        ce = 1'b1; first_v = -1; first_o = -1;
        for (int e = 1; e <= 120; e++) begin
            din = (NCH*WIDTH)'($urandom);
            din[WIDTH-1:0] = (e == 100) ? '1 : '0;
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid) begin
                errors++;
                $display("FAIL latency_model edge=%0d dout=%h valid=%b want dout=%h valid=%b", e, dout, valid, m_dout, m_valid);
            end
            if (first_v < 0 && valid[0]) first_v = e;
            if (first_o < 0 && dout[WIDTH-1:0] != '0) first_o = e;
        end
        checks++;
        if (first_v !== 7) begin errors++; $display("FAIL latency_valid_rise got=%0d want=7", first_v); end
        checks++;
        if (first_o !== 106) begin errors++; $display("FAIL latency_pulse_edge got=%0d want=106", first_o); end
    endtask

    task automatic test_ce_gating();
        int first_o;
        do_reset();
        write_tap(3, 3);
        first_o = -1;
        for (int i = 0; i < 40; i++) begin
            ce = (i % 2 == 0);
            din = (NCH*WIDTH)'($urandom);
            din[3*WIDTH +: WIDTH] = (i == 20) ? '1 : '0;
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid) begin
                errors++;
                $display("FAIL ce_gating_model clk=%0d dout=%h valid=%b want dout=%h valid=%b", i, dout, valid, m_dout, m_valid);
            end
            if (first_o < 0 && dout[3*WIDTH +: WIDTH] != '0) first_o = i;
        end
        checks++;
        if (first_o !== 28) begin errors++; $display("FAIL ce_gating_pulse_clk got=%0d want=28", first_o); end
    endtask

    task automatic test_flush_write();
        int fv0, fv1;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
        end
        flush = 1'b1; tap_wr = 1'b1; tap_ch = 3'd1; tap = 5'd2;
        cyc();
        flush = 1'b0; tap_wr = 1'b0;
        checks++;
        if (valid !== '0 || dout !== '0) begin
            errors++;
            $display("FAIL flush_clear dout=%h valid=%b want 0 and 0", dout, valid);
        end
        fv0 = -1; fv1 = -1;
        for (int e = 1; e <= 6; e++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid) begin
                errors++;
                $display("FAIL flush_model edge=%0d dout=%h valid=%b want dout=%h valid=%b", e, dout, valid, m_dout, m_valid);
            end
            if (fv0 < 0 && valid[0]) fv0 = e;
            if (fv1 < 0 && valid[1]) fv1 = e;
        end
        checks++;
        if (fv0 !== 2) begin errors++; $display("FAIL flush_valid_tap0 got=%0d want=2", fv0); end
        checks++;
        if (fv1 !== 4) begin errors++; $display("FAIL flush_valid_tap2 got=%0d want=4", fv1); end
    endtask

    task automatic test_invalid_ch();
        int lat [NCH];
        do_reset();
        write_tap(2, 4);
        for (int k = 6; k <= 7; k++) begin
            tap_wr = 1'b1; tap_ch = CHW'(k); tap = 5'd9;
            cyc();
            tap_wr = 1'b0;
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL invalid_err_high ch=%0d got=%b want=1", k, err); end
            cyc();
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL invalid_err_low ch=%0d got=%b want=0", k, err); end
        end
        flush = 1'b1; cyc(); flush = 1'b0;
        ce = 1'b1; din = '0;
        for (int c = 0; c < NCH; c++) lat[c] = -1;
        for (int i = 0; i < 20; i++) begin
            din = (i == 8) ? '1 : '0;
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid) begin
                errors++;
                $display("FAIL invalid_model i=%0d dout=%h valid=%b want dout=%h valid=%b", i, dout, valid, m_dout, m_valid);
            end
            for (int c = 0; c < NCH; c++)
                if (lat[c] < 0 && dout[c*WIDTH +: WIDTH] != '0) lat[c] = i - 8;
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (lat[c] !== ((c == 2) ? 5 : 1)) begin
                errors++;
                $display("FAIL invalid_latency ch=%0d got=%0d want=%0d", c, lat[c], (c == 2) ? 5 : 1);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ce     = ($urandom % 4) != 0;
            flush  = ($urandom % 40) == 0;
            tap_wr = ($urandom % 5) == 0;
            tap_ch = CHW'($urandom_range(0, 7));
            tap    = SW'($urandom);
            din    = (NCH*WIDTH)'($urandom);
            cyc();
            checks++;
            if (dout !== m_dout || valid !== m_valid || busy !== m_busy || err !== m_err) begin
                errors++;
                $display("FAIL random i=%0d dout=%h valid=%b busy=%b err=%b want dout=%h valid=%b busy=%b err=%b",
                         i, dout, valid, busy, err, m_dout, m_valid, m_busy, m_err);
            end
        end
        ce = 1'b0; flush = 1'b0; tap_wr = 1'b0;
    endtask

`ifdef SBIT_TAP_GLITCHLESS_EN
    task automatic test_glitchless();
        int busy_cnt;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
        end
        din = (NCH*WIDTH)'($urandom);
        write_tap(2, 31);
        busy_cnt = busy[2] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            din = (NCH*WIDTH)'($urandom);
            cyc();
            checks++;
            if (dout !== m_dout || valid[2] !== 1'b1 || busy !== m_busy) begin
                errors++;
                $display("FAIL glitchless_model i=%0d dout=%h valid2=%b busy=%b want dout=%h valid2=1 busy=%b",
                         i, dout, valid[2], busy, m_dout, m_busy);
            end
            if (busy[2]) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 31) begin errors++; $display("FAIL glitchless_busy_len got=%0d want=31", busy_cnt); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; ce = 1'b0; flush = 1'b0; tap_wr = 1'b0;
        tap_ch = '0; tap = '0; din = '0;
        test_reset();
        test_latency();
        test_ce_gating();
        test_flush_write();
        test_invalid_ch();
        test_random();
`ifdef SBIT_TAP_GLITCHLESS_EN
        test_glitchless();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
